// File: rtl/clz_share_arbiter.sv
// Round-robin front end that shares one leading-zero counter between NUM_REQ
// requesters through a two-stage stallable pipeline (capture, then count).
module clz_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int W_IN    = 8,
  parameter int W_OUT   = $clog2(W_IN),
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*W_IN-1:0] req_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [W_OUT-1:0]        rsp_count,
  output logic                    rsp_zero
);

  // All-zero input yields all ones; consumers qualify the count with rsp_zero.
  function automatic logic [W_OUT-1:0] count_lead_zero(input logic [W_IN-1:0] x);
    logic [W_OUT-1:0] cnt;
    cnt = W_OUT'(W_IN - 1);
    for (int i = 0; i < W_IN; i++) begin
      if (x[i]) cnt = W_OUT'(W_IN - 1 - i);
    end
    return cnt;
  endfunction

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             s1_valid_q, s1_valid_d;
  logic [W_IN-1:0]  s1_data_q, s1_data_d;
  logic [ID_W-1:0]  s1_id_q, s1_id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [W_OUT-1:0] rsp_count_q, rsp_count_d;
  logic             rsp_zero_q, rsp_zero_d;

  logic             out_free, s1_free, grant_vld, accept;
  logic [ID_W-1:0]  grant_id;
  logic [W_IN-1:0]  grant_data;
  logic [W_OUT-1:0] clz_count;

  // Arbitrate: first valid requester at or after ptr, wrapping.
  always_comb begin
    int              idx_i;
    logic [ID_W-1:0] idx;
    idx_i     = 0;
    idx       = '0;
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_i = (int'(ptr_q) + k) % NUM_REQ;
      idx   = ID_W'(idx_i);
      if (!grant_vld && req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_id  = idx;
      end
    end
  end

  always_comb begin
    out_free   = !rsp_valid_q || rsp_ready;
    s1_free    = !s1_valid_q || out_free;
    accept     = grant_vld && s1_free && !rst;
    req_ready  = '0;
    if (accept) req_ready[grant_id] = 1'b1;
    grant_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_id) grant_data = req_data[i*W_IN +: W_IN];
    end
    clz_count  = count_lead_zero(s1_data_q);
  end

  // Stage 1 capture and stage 2 compute/register.
  always_comb begin
    ptr_d       = ptr_q;
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_id_d     = s1_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_count_d = rsp_count_q;
    rsp_zero_d  = rsp_zero_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_data_d  = grant_data;
      s1_id_d    = grant_id;
      ptr_d      = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    end else if (s1_free) begin
      s1_valid_d = 1'b0;
    end
    if (out_free) begin
      rsp_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        rsp_count_d = clz_count;
        rsp_zero_d  = (s1_data_q == '0);
        rsp_id_d    = s1_id_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      s1_valid_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_count_q <= '0;
      rsp_zero_q  <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      s1_valid_q  <= s1_valid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_count_q <= rsp_count_d;
      rsp_zero_q  <= rsp_zero_d;
    end
  end

  // Stage-1 payload is qualified by s1_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    s1_data_q <= s1_data_d;
    s1_id_q   <= s1_id_d;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_count = rsp_count_q;
  assign rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_clz_share_arbiter.sv
// Bench for clz_share_arbiter: scoreboard of expected responses plus grant-order checks.
module tb_clz_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [2:0]  rsp_count;
  logic        rsp_zero;

  always #5 clk = ~clk;

  clz_share_arbiter #(.NUM_REQ(4), .W_IN(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_count (rsp_count),
    .rsp_zero  (rsp_zero)
  );

  typedef struct packed {
    logic [1:0] id;
    logic [2:0] count;
    logic       zero;
  } rsp_t;

  typedef struct {
    logic [7:0] data;
    logic [2:0] count;
    logic       zero;
  } vec_t;

  rsp_t exp_q[$];
  int   grant_log[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Observe the cycle's handshakes (the edge that follows commits them).
  task automatic neg_sample();
    rsp_t e;
    @(negedge clk);
    if (!rst) begin
      chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      for (int i = 0; i < 4; i++)
        if (req_valid[i] && req_ready[i]) grant_log.push_back(i);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected actual id=%0d count=%0d zero=%0d required none",
                   rsp_id, rsp_count, rsp_zero);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_fields", 32'({rsp_id, rsp_count, rsp_zero}), 32'(e));
        end
      end
    end
  endtask

  task automatic after_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    grant_log.delete();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 40) begin
      neg_sample();
      after_pos();
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  task automatic send_one(input int r, input logic [7:0] d, input logic [2:0] c, input logic z);
    bit got;
    got = 1'b0;
    req_data[r*8 +: 8] = d;
    req_valid = 4'(1 << r);
    exp_q.push_back({2'(r), c, z});
    for (int k = 0; k < 20 && !got; k++) begin
      neg_sample();
      if (req_ready[r]) got = 1'b1;
      after_pos();
    end
    req_valid = '0;
    if (!got) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_grants(input int num);
    int n;
    n = 0;
    while (grant_log.size() < num && n < 40) begin
      neg_sample();
      after_pos();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[11];
    logic [7:0] bp_d[4];
    logic [2:0] bp_c[4];
    rsp_t       snap;
    bit         have_snap, acc, got;
    int         si, acc_total, n;

    for (int k = 0; k < 8; k++) tbl[k] = '{8'(1 << k), 3'(7 - k), 1'b0};
    tbl[8]  = '{8'h00, 3'd7, 1'b1};
    tbl[9]  = '{8'hFF, 3'd0, 1'b0};
    tbl[10] = '{8'h3C, 3'd2, 1'b0};
    bp_d = '{8'h20, 8'h08, 8'h03, 8'h11};
    bp_c = '{3'd2, 3'd4, 3'd6, 3'd3};

    // Reset state, with requests already pending.
    rst       = 1'b1;
    req_valid = 4'hF;
    req_data  = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_count", 32'(rsp_count), 0);
    chk("rst_rsp_zero", 32'(rsp_zero), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    req_valid = '0;

    // Single operand latency: requester 2, 8'h10.
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_data[23:16] = 8'h10;
    req_valid = 4'b0100;
    exp_q.push_back({2'd2, 3'd3, 1'b0});
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      neg_sample();
      if (req_ready[2]) got = 1'b1;
      after_pos();
    end
    req_valid = '0;
    chk("lat_accept", 32'(got), 1);
    neg_sample();
    chk("lat_not_yet", 32'(rsp_valid), 0);
    after_pos();
    neg_sample();
    chk("lat_valid", 32'(rsp_valid), 1);
    chk("lat_rsp", 32'({rsp_id, rsp_count, rsp_zero}), 32'({2'd2, 3'd3, 1'b0}));
    after_pos();
    drain("lat_drain");

    // Round robin with all four requesters held valid.
    do_reset();
    req_data = {8'h00, 8'h01, 8'h40, 8'h80};
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back({2'd0, 3'd0, 1'b0});
      exp_q.push_back({2'd1, 3'd1, 1'b0});
      exp_q.push_back({2'd2, 3'd7, 1'b0});
      exp_q.push_back({2'd3, 3'd7, 1'b1});
    end
    req_valid = 4'hF;
    n = 0;
    while (grant_log.size() < 8 && n < 40) begin
      neg_sample();
      after_pos();
      n++;
    end
    req_valid = '0;
    chk("rr_cycles", n, 8);
    chk("rr_count", grant_log.size(), 8);
    for (int i = 0; i < grant_log.size(); i++) chk("rr_order", grant_log[i], i % 4);
    drain("rr_drain");

    // Backpressure: requester 1 streams while rsp_ready is low.
    rsp_ready = 1'b0;
    si = 0;
    acc_total = 0;
    have_snap = 1'b0;
    snap = '0;
    req_data[15:8] = bp_d[0];
    req_valid = 4'b0010;
    exp_q.push_back({2'd1, bp_c[0], 1'b0});
    for (int c = 0; c < 5; c++) begin
      neg_sample();
      acc = req_ready[1];
      if (c >= 2) chk("bp_ready_low", 32'(req_ready), 0);
      if (rsp_valid) begin
        if (have_snap) chk("bp_stable", 32'({rsp_id, rsp_count, rsp_zero}), 32'(snap));
        else begin
          snap = {rsp_id, rsp_count, rsp_zero};
          have_snap = 1'b1;
        end
      end
      after_pos();
      if (acc) begin
        acc_total++;
        si++;
        req_data[15:8] = bp_d[si];
        exp_q.push_back({2'd1, bp_c[si], 1'b0});
      end
    end
    chk("bp_accepts", acc_total, 2);
    chk("bp_rsp_held", 32'(have_snap), 1);
    rsp_ready = 1'b1;
    n = 0;
    while (si < 4 && n < 30) begin
      neg_sample();
      acc = req_ready[1];
      after_pos();
      if (acc) begin
        si++;
        if (si < 4) begin
          req_data[15:8] = bp_d[si];
          exp_q.push_back({2'd1, bp_c[si], 1'b0});
        end
      end
      n++;
    end
    req_valid = '0;
    chk("bp_all_accepted", si, 4);
    drain("bp_drain");

    // Requesters 0 and 3 only, pointer at 1.
    do_reset();
    send_one(0, 8'h80, 3'd0, 1'b0);
    drain("rr2_prep_drain");
    grant_log.delete();
    req_data[7:0]   = 8'h02;
    req_data[31:24] = 8'hFF;
    exp_q.push_back({2'd3, 3'd0, 1'b0});
    exp_q.push_back({2'd0, 3'd6, 1'b0});
    exp_q.push_back({2'd3, 3'd0, 1'b0});
    req_valid = 4'b1001;
    wait_grants(3);
    req_valid = '0;
    chk("rr2_count", grant_log.size(), 3);
    if (grant_log.size() >= 3) begin
      chk("rr2_first", grant_log[0], 3);
      chk("rr2_second", grant_log[1], 0);
      chk("rr2_third", grant_log[2], 3);
    end
    drain("rr2_drain");

    // Reset with both stages full; the dropped operands must never appear.
    rsp_ready = 1'b0;
    req_data[15:8] = 8'h55;
    req_valid = 4'b0010;
    repeat (3) begin
      neg_sample();
      after_pos();
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("mid_rst_req_ready", 32'(req_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    grant_log.delete();
    req_data[15:8]  = 8'h04;
    req_data[31:24] = 8'h00;
    exp_q.push_back({2'd1, 3'd5, 1'b0});
    exp_q.push_back({2'd3, 3'd7, 1'b1});
    req_valid = 4'b1010;
    wait_grants(2);
    req_valid = '0;
    chk("mid_rst_count", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      chk("mid_rst_first", grant_log[0], 1);
      chk("mid_rst_second", grant_log[1], 3);
    end
    drain("mid_rst_drain");

    // Operand table: single-bit sweep plus zero and dense patterns.
    for (int i = 0; i < 11; i++) send_one(i % 4, tbl[i].data, tbl[i].count, tbl[i].zero);
    drain("tbl_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
